obj_position_ctrl: RTL and testbench

Player-object position controller that produces the 10-bit object position consumed by the per-object pixel-offset stage. Raw push-buttons are synchronized and debounced, and each debounced press becomes one grid step. Steps are applied only on the frame tick, so the position never changes mid-frame. The position is clamped to the visible 640x480 area, less one 32-pixel sprite.

---
 rtl/obj_position_ctrl.sv | 199 +++++++++++++++++++
 tb/tb_obj_position_ctrl.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/obj_position_ctrl.sv
// Player-object position controller: debounced push-buttons queue one grid step
// each, applied on the frame tick and clamped to the visible area minus one sprite.
module obj_position_ctrl #(
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int STEP            = 32,
    parameter int X_MAX           = 608,
    parameter int Y_MAX           = 448,
    parameter int X_INIT          = 304,
    parameter int Y_INIT          = 448
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic       btn_left,
    input  logic       btn_right,
    input  logic       frame_tick,
    input  logic       respawn,
    output logic [9:0] obj_x_pos,
    output logic [9:0] obj_y_pos,
    output logic       moved,
    output logic       blocked
);

    localparam int              CW       = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0]   CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0]   CNT_ONE  = CW'(1);
    localparam logic [10:0]     STEP_W   = 11'(STEP);
    localparam logic [10:0]     X_MAX_W  = 11'(X_MAX);
    localparam logic [10:0]     Y_MAX_W  = 11'(Y_MAX);
    localparam logic [9:0]      X_INIT_P = 10'(X_INIT);
    localparam logic [9:0]      Y_INIT_P = 10'(Y_INIT);

    typedef enum logic [1:0] {
        RELEASED     = 2'd0,
        PRESS_WAIT   = 2'd1,
        HELD         = 2'd2,
        RELEASE_WAIT = 2'd3
    } db_state_t;

    // Bit order everywhere: 0 = up, 1 = down, 2 = left, 3 = right (also the priority order).
    logic [3:0]  btn_raw;
    logic [3:0]  sync1_r;
    logic [3:0]  sync2_r;
    logic [3:0]  press_s;
    logic [3:0]  pending_r;
    logic [10:0] x_w;
    logic [10:0] y_w;
    logic        step_valid_s;
    logic        step_legal_s;
    logic [9:0]  x_next_s;
    logic [9:0]  y_next_s;

    assign btn_raw = {btn_right, btn_left, btn_down, btn_up};
    assign x_w     = {1'b0, obj_x_pos};
    assign y_w     = {1'b0, obj_y_pos};

    // Two-flop synchronizer for the asynchronous buttons.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_r <= 4'b0000;
            sync2_r <= 4'b0000;
        end else begin
            sync1_r <= btn_raw;
            sync2_r <= sync1_r;
        end
    end

    for (genvar i = 0; i < 4; i++) begin : g_db
        db_state_t     state_r;
        db_state_t     state_s;
        logic [CW-1:0] cnt_r;
        logic [CW-1:0] cnt_s;
        logic          press_b;

        always_ff @(posedge clk) begin
            if (reset) begin
                state_r <= RELEASED;
                cnt_r   <= '0;
            end else begin
                state_r <= state_s;
                cnt_r   <= cnt_s;
            end
        end

        // Only the PRESS_WAIT -> HELD edge counts as a press; a bounce back from
        // RELEASE_WAIT re-enters HELD silently, so a held button steps once.
        always_comb begin
            state_s = state_r;
            cnt_s   = cnt_r;
            press_b = 1'b0;
            case (state_r)
                RELEASED: begin
                    cnt_s = '0;
                    if (sync2_r[i]) begin
                        state_s = PRESS_WAIT;
                    end else begin
                        state_s = RELEASED;
                    end
                end
                PRESS_WAIT: begin
                    if (!sync2_r[i]) begin
                        state_s = RELEASED;
                        cnt_s   = '0;
                    end else if (cnt_r == CNT_LAST) begin
                        state_s = HELD;
                        cnt_s   = '0;
                        press_b = 1'b1;
                    end else begin
                        cnt_s = cnt_r + CNT_ONE;
                    end
                end
                HELD: begin
                    cnt_s = '0;
                    if (!sync2_r[i]) begin
                        state_s = RELEASE_WAIT;
                    end else begin
                        state_s = HELD;
                    end
                end
                RELEASE_WAIT: begin
                    if (sync2_r[i]) begin
                        state_s = HELD;
                        cnt_s   = '0;
                    end else if (cnt_r == CNT_LAST) begin
                        state_s = RELEASED;
                        cnt_s   = '0;
                    end else begin
                        cnt_s = cnt_r + CNT_ONE;
                    end
                end
                default: begin
                    state_s = RELEASED;
                    cnt_s   = '0;
                end
            endcase
        end

        assign press_s[i] = press_b;
    end

    // Select the highest-priority pending direction and bounds-check it in 11 bits.
    always_comb begin
        step_valid_s = 1'b0;
        step_legal_s = 1'b0;
        x_next_s     = obj_x_pos;
        y_next_s     = obj_y_pos;
        if (pending_r[0]) begin
            step_valid_s = 1'b1;
            step_legal_s = (y_w >= STEP_W);
            y_next_s     = 10'(y_w - STEP_W);
        end else if (pending_r[1]) begin
            step_valid_s = 1'b1;
            step_legal_s = ((y_w + STEP_W) <= Y_MAX_W);
            y_next_s     = 10'(y_w + STEP_W);
        end else if (pending_r[2]) begin
            step_valid_s = 1'b1;
            step_legal_s = (x_w >= STEP_W);
            x_next_s     = 10'(x_w - STEP_W);
        end else if (pending_r[3]) begin
            step_valid_s = 1'b1;
            step_legal_s = ((x_w + STEP_W) <= X_MAX_W);
            x_next_s     = 10'(x_w + STEP_W);
        end else begin
            step_valid_s = 1'b0;
        end
    end

    // Position, pending flags and status pulses; respawn beats frame_tick.
    always_ff @(posedge clk) begin
        if (reset) begin
            obj_x_pos <= X_INIT_P;
            obj_y_pos <= Y_INIT_P;
            pending_r <= 4'b0000;
            moved     <= 1'b0;
            blocked   <= 1'b0;
        end else if (respawn) begin
            obj_x_pos <= X_INIT_P;
            obj_y_pos <= Y_INIT_P;
            pending_r <= 4'b0000;
            moved     <= 1'b0;
            blocked   <= 1'b0;
        end else if (frame_tick) begin
            // Presses landing on the tick edge survive into the next frame.
            pending_r <= press_s;
            moved     <= step_valid_s & step_legal_s;
            blocked   <= step_valid_s & ~step_legal_s;
            if (step_valid_s && step_legal_s) begin
                obj_x_pos <= x_next_s;
                obj_y_pos <= y_next_s;
            end
        end else begin
            pending_r <= pending_r | press_s;
            moved     <= 1'b0;
            blocked   <= 1'b0;
        end
    end

endmodule

// File: tb/tb_obj_position_ctrl.sv
// Self-checking bench for obj_position_ctrl: directed scenarios plus random
// button/tick traffic compared every cycle against a run-length reference model.
module tb_obj_position_ctrl;

    localparam int D = 4;

    logic       clk;
    logic       rst;
    logic [3:0] btn;
    logic       tick;
    logic       rsp;
    logic [9:0] obj_x_pos;
    logic [9:0] obj_y_pos;
    logic       moved;
    logic       blocked;

    int vectors = 0;
    int errors  = 0;

    // Reference model state: positions, pulses, pending set, and a debounce
    // model that flips the accepted level after D+1 consecutive opposite samples.
    int       m_x;
    int       m_y;
    bit       m_moved;
    bit       m_blocked;
    bit [3:0] m_pend;
    bit [3:0] m_s1;
    bit [3:0] m_s2;
    bit [3:0] m_acc;
    int       m_run [4];

    obj_position_ctrl #(.DEBOUNCE_CYCLES(D)) dut (
        .clk        (clk),
        .reset      (rst),
        .btn_up     (btn[0]),
        .btn_down   (btn[1]),
        .btn_left   (btn[2]),
        .btn_right  (btn[3]),
        .frame_tick (tick),
        .respawn    (rsp),
        .obj_x_pos  (obj_x_pos),
        .obj_y_pos  (obj_y_pos),
        .moved      (moved),
        .blocked    (blocked)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input int obs, input int exp);
        vectors++;
        if (obs != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_step();
        bit [3:0] press;
        int       dir;
        int       nx;
        int       ny;
        press = 4'b0000;
        if (rst) begin
            m_x = 304; m_y = 448; m_moved = 0; m_blocked = 0;
            m_pend = 0; m_s1 = 0; m_s2 = 0; m_acc = 0;
            for (int i = 0; i < 4; i++) m_run[i] = 0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (m_s2[i] != m_acc[i]) begin
                    m_run[i]++;
                    if (m_run[i] == D + 1) begin
                        m_acc[i] = m_s2[i];
                        m_run[i] = 0;
                        if (m_acc[i]) press[i] = 1'b1;
                    end
                end else begin
                    m_run[i] = 0;
                end
            end
            m_s2 = m_s1;
            m_s1 = btn;
            m_moved = 0;
            m_blocked = 0;
            if (rsp) begin
                m_x = 304; m_y = 448; m_pend = 0;
            end else if (tick) begin
                dir = -1;
                for (int i = 3; i >= 0; i--) if (m_pend[i]) dir = i;
                nx = m_x; ny = m_y;
                case (dir)
                    0: ny = m_y - 32;
                    1: ny = m_y + 32;
                    2: nx = m_x - 32;
                    3: nx = m_x + 32;
                    default: ;
                endcase
                if (dir >= 0) begin
                    if (nx >= 0 && nx <= 608 && ny >= 0 && ny <= 448) begin
                        m_x = nx; m_y = ny; m_moved = 1;
                    end else begin
                        m_blocked = 1;
                    end
                end
                m_pend = press;
            end else begin
                m_pend = m_pend | press;
            end
        end
    endtask

    // One clock: model the edge, compare just after it, return at the negedge.
    task automatic cyc();
        @(posedge clk);
        model_step();
        #1;
        check_val("x_pos", int'(obj_x_pos), m_x);
        check_val("y_pos", int'(obj_y_pos), m_y);
        check_val("moved", int'(moved), int'(m_moved));
        check_val("blocked", int'(blocked), int'(m_blocked));
        @(negedge clk);
    endtask

    task automatic press(input int idx);
        btn[idx] = 1'b1;
        repeat (8) cyc();
        btn[idx] = 1'b0;
        repeat (8) cyc();
    endtask

    task automatic frame();
        tick = 1'b1;
        cyc();
        tick = 1'b0;
    endtask

    initial begin
        clk = 1'b0; rst = 1'b0; btn = 4'b0000; tick = 1'b0; rsp = 1'b0;
        @(negedge clk);

        // Reset values
        rst = 1'b1;
        cyc(); cyc();
        rst = 1'b0;
        check_val("rst_x", int'(obj_x_pos), 304);
        check_val("rst_y", int'(obj_y_pos), 448);
        check_val("rst_pulses", int'({moved, blocked}), 0);

        // Single press, no auto-repeat while held
        btn[0] = 1'b1;
        repeat (20) cyc();
        frame();
        check_val("up_y", int'(obj_y_pos), 416);
        check_val("up_moved", int'(moved), 1);
        cyc();
        frame();
        check_val("hold_y1", int'(obj_y_pos), 416);
        frame();
        check_val("hold_y2", int'(obj_y_pos), 416);
        check_val("hold_moved", int'(moved), 0);
        btn[0] = 1'b0;
        repeat (10) cyc();

        // Glitch shorter than the debounce window
        btn[2] = 1'b1;
        repeat (3) cyc();
        btn[2] = 1'b0;
        repeat (10) cyc();
        frame();
        check_val("glitch_x", int'(obj_x_pos), 304);
        check_val("glitch_pulses", int'({moved, blocked}), 0);

        // Bottom edge, then walk left into the left edge
        press(1); frame();
        check_val("down_y", int'(obj_y_pos), 448);
        press(1); frame();
        check_val("down_blocked", int'(blocked), 1);
        check_val("down_clamp_y", int'(obj_y_pos), 448);
        for (int k = 0; k < 9; k++) begin
            press(2); frame();
        end
        check_val("left_x", int'(obj_x_pos), 16);
        press(2); frame();
        check_val("left_blocked", int'(blocked), 1);
        check_val("left_clamp_x", int'(obj_x_pos), 16);
        rsp = 1'b1; cyc(); rsp = 1'b0;
        check_val("respawn_x", int'(obj_x_pos), 304);

        // Priority: up wins over right, right is discarded
        btn = 4'b1001;
        repeat (8) cyc();
        btn = 4'b0000;
        repeat (8) cyc();
        frame();
        check_val("prio_y", int'(obj_y_pos), 416);
        check_val("prio_x", int'(obj_x_pos), 304);
        frame();
        check_val("discard_pulses", int'({moved, blocked}), 0);

        // Respawn overrides a simultaneous frame tick
        press(0); frame();
        press(3); frame();
        check_val("pre_rsp_x", int'(obj_x_pos), 336);
        check_val("pre_rsp_y", int'(obj_y_pos), 384);
        press(0);
        rsp = 1'b1; tick = 1'b1;
        cyc();
        rsp = 1'b0; tick = 1'b0;
        check_val("rsp_x", int'(obj_x_pos), 304);
        check_val("rsp_y", int'(obj_y_pos), 448);
        check_val("rsp_moved", int'(moved), 0);
        frame();
        check_val("post_rsp_pulses", int'({moved, blocked}), 0);

        // Random traffic, compared every cycle against the model
        for (int n = 0; n < 3000; n++) begin
            for (int i = 0; i < 4; i++)
                if ($urandom_range(0, 9) == 0) btn[i] = ~btn[i];
            tick = ($urandom_range(0, 5) == 0);
            rsp  = ($urandom_range(0, 63) == 0);
            rst  = ($urandom_range(0, 499) == 0);
            cyc();
        end
        btn = 4'b0000; tick = 1'b0; rsp = 1'b0; rst = 1'b0;
        cyc();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
